mem_req_adapter: RTL and testbench

Upstream neighbour of the storage controller. It accepts the vector core's req/gnt/rvalid memory interface and buffers requests in a small FIFO. It serialises those requests onto the storage controller's single-outstanding interface: a one-cycle memory_access pulse, address and data held stable until out_valid. It also returns rdata and an error flag in request order, with a timeout watchdog and write-range checking.

---
 rtl/mem_adapter_pkg.sv | 20 ++
 rtl/mem_req_fifo.sv | 41 ++++
 rtl/mem_req_adapter.sv | 143 ++++++++++++++
 tb/tb_mem_req_adapter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_adapter_pkg.sv
// Shared types for the core-to-storage-controller request adapter.
package mem_adapter_pkg;

  localparam logic [31:0] SRAM_LIMIT_DEF = 32'h0000_0FFF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } adapter_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous request FIFO with full/empty flags; depth must be a power of two.
module mem_req_fifo
  import mem_adapter_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  mem_req_t wdata_i,
  input  logic     pop_i,
  output mem_req_t rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned AW = $clog2(Depth);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wptr_q, rptr_q;
  mem_req_t    mem_q [Depth];

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i && !full_o) wptr_q <= wptr_q + 1'b1;
      if (pop_i && !empty_o) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/mem_req_adapter.sv
// Buffers core req/gnt requests and serialises them onto the single-outstanding
// storage controller interface, returning in-order responses with timeout and range checks.
module mem_req_adapter
  import mem_adapter_pkg::*;
#(
  parameter int unsigned MEM_W       = 32,
  parameter int unsigned REQ_DEPTH   = 2,
  parameter logic [31:0] SRAM_LIMIT  = SRAM_LIMIT_DEF,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_req_i,
  output logic               mem_gnt_o,
  input  logic [31:0]        mem_addr_i,
  input  logic               mem_we_i,
  input  logic [MEM_W/8-1:0] mem_be_i,
  input  logic [MEM_W-1:0]   mem_wdata_i,
  output logic               mem_rvalid_o,
  output logic [MEM_W-1:0]   mem_rdata_o,
  output logic               mem_err_o,
  output logic               sc_memory_access_o,
  output logic               sc_is_writing_o,
  output logic [31:0]        sc_addr_o,
  output logic [31:0]        sc_d_in_o,
  output logic [3:0]         sc_be_o,
  input  logic [31:0]        sc_d_out_i,
  input  logic               sc_out_valid_i,
  output logic               busy_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  adapter_state_e  state_q, state_d;
  mem_req_t        hold_q, hold_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  mem_req_t fifo_wdata, fifo_rdata;
  logic     fifo_push, fifo_pop, fifo_full, fifo_empty;

  // Grant is held low while in reset even though the FIFO is empty then.
  assign mem_gnt_o = rst && !fifo_full;
  assign fifo_push = mem_req_i && mem_gnt_o;

  assign fifo_wdata.addr  = mem_addr_i;
  assign fifo_wdata.we    = mem_we_i;
  assign fifo_wdata.be    = mem_be_i[3:0];
  assign fifo_wdata.wdata = mem_wdata_i;

  mem_req_fifo #(
    .Depth (REQ_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hold_d   = fifo_rdata;
          rdata_d  = '0;
          err_d    = 1'b0;
          cnt_d    = '0;
          if (fifo_rdata.we && (fifo_rdata.addr >= SRAM_LIMIT)) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A completion on the last counted cycle still wins over the timeout.
        if (sc_out_valid_i) begin
          rdata_d = hold_q.we ? '0 : sc_d_out_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CntLast) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sc_memory_access_o = (state_q == ISSUE);
  assign sc_is_writing_o    = hold_q.we;
  assign sc_addr_o          = hold_q.addr;
  assign sc_d_in_o          = hold_q.wdata;
  assign sc_be_o            = hold_q.be;

  assign mem_rvalid_o = (state_q == RESP);
  assign mem_rdata_o  = (state_q == RESP) ? rdata_q : '0;
  assign mem_err_o    = (state_q == RESP) && err_q;

  assign busy_o = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_mem_req_adapter.sv
// Scoreboard bench: stimulus pushes expected responses, a monitor pops them on rvalid,
// and a behavioural storage controller model answers issue pulses.
module tb_mem_req_adapter;

  localparam int unsigned TO_CYC = 16;
  localparam logic [31:0] LIMIT  = 32'h0000_0FFF;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_i, mem_gnt_o, mem_we_i;
  logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic [3:0]  mem_be_i;
  logic        mem_rvalid_o, mem_err_o;
  logic        sc_memory_access_o, sc_is_writing_o, sc_out_valid_i, busy_o;
  logic [31:0] sc_addr_o, sc_d_in_o, sc_d_out_i;
  logic [3:0]  sc_be_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int exp_pulses = 0;
  int last_gnt_cyc;
  logic last_waited;

  resp_t       exp_q[$];
  int          lat_q[$];
  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] sc_mem  [logic [29:0]];

  mem_req_adapter #(
    .MEM_W       (32),
    .REQ_DEPTH   (2),
    .SRAM_LIMIT  (LIMIT),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .mem_req_i          (mem_req_i),
    .mem_gnt_o          (mem_gnt_o),
    .mem_addr_i         (mem_addr_i),
    .mem_we_i           (mem_we_i),
    .mem_be_i           (mem_be_i),
    .mem_wdata_i        (mem_wdata_i),
    .mem_rvalid_o       (mem_rvalid_o),
    .mem_rdata_o        (mem_rdata_o),
    .mem_err_o          (mem_err_o),
    .sc_memory_access_o (sc_memory_access_o),
    .sc_is_writing_o    (sc_is_writing_o),
    .sc_addr_o          (sc_addr_o),
    .sc_d_in_o          (sc_d_in_o),
    .sc_be_o            (sc_be_o),
    .sc_d_out_i         (sc_d_out_i),
    .sc_out_valid_i     (sc_out_valid_i),
    .busy_o             (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s bound expired", name);
  endtask

  function automatic logic [31:0] dflt(input logic [29:0] w);
    return {w[15:0] ^ 16'h5A5A, ~w[15:0]};
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
    return dflt(a[31:2]);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] b,
                                        input logic [31:0] d);
    logic [31:0] v = old;
    for (int i = 0; i < 4; i++) if (b[i]) v[8*i +: 8] = d[8*i +: 8];
    return v;
  endfunction

  // Issue one request, wait for its grant and record the response it must produce.
  task automatic send(input logic [31:0] a, input logic w, input logic [3:0] b,
                      input logic [31:0] d, input int lat);
    int    n = 0;
    resp_t e;
    mem_req_i   = 1'b1;
    mem_addr_i  = a;
    mem_we_i    = w;
    mem_be_i    = b;
    mem_wdata_i = d;
    last_waited = 1'b0;
    #1;
    while (!mem_gnt_o && n < 200) begin
      last_waited = 1'b1;
      @(negedge clk);
      #1;
      n++;
    end
    if (!mem_gnt_o) begin
      fail_now("gnt_wait");
      mem_req_i = 1'b0;
      return;
    end
    last_gnt_cyc = cyc;
    if (w && a >= LIMIT) begin
      e.rdata = '0; e.err = 1'b1;
    end else if (!w && a[31:16] == 16'h0001) begin
      e.rdata = '0; e.err = 1'b1;
      exp_pulses++;
    end else begin
      exp_pulses++;
      lat_q.push_back(lat);
      if (w) begin
        ref_mem[a[31:2]] = merge(ref_rd(a), b, d);
        e.rdata = '0;
      end else begin
        e.rdata = ref_rd(a);
      end
      e.err = 1'b0;
    end
    exp_q.push_back(e);
    @(negedge clk);
    mem_req_i = 1'b0;
  endtask

  task automatic wait_access();
    int n = 0;
    while (!sc_memory_access_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!sc_memory_access_o) fail_now("access_wait");
  endtask

  task automatic wait_rvalid();
    int n = 0;
    while (!mem_rvalid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!mem_rvalid_o) fail_now("rvalid_wait");
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || busy_o) fail_now("drain");
  endtask

  // Storage controller model: answers each issue pulse after a per-request latency;
  // addresses in 0x0001_xxxx never answer in time and send a late completion instead.
  initial begin : ctrl
    logic        pend = 1'b0, to_mode = 1'b0, prev_acc = 1'b0;
    int          wcnt = 0, lat = 0;
    logic [31:0] c_addr = '0, c_wdata = '0;
    logic        c_we = 1'b0;
    logic [3:0]  c_be = '0;
    sc_out_valid_i = 1'b0;
    sc_d_out_i     = '0;
    forever begin
      @(negedge clk);
      sc_out_valid_i = 1'b0;
      if (!rst) begin
        pend     = 1'b0;
        prev_acc = 1'b0;
        continue;
      end
      if (pend) begin
        if (!to_mode || wcnt <= TO_CYC - 1)
          chk("sc_hold", {sc_addr_o, sc_is_writing_o, sc_be_o, sc_d_in_o},
              {c_addr, c_we, c_be, c_wdata});
        if (to_mode) begin
          if (wcnt == TO_CYC + 1) begin
            sc_out_valid_i = 1'b1;
            sc_d_out_i     = 32'hBAD0_BAD0;
            pend           = 1'b0;
          end
        end else if (wcnt == lat) begin
          sc_out_valid_i = 1'b1;
          sc_d_out_i = c_we ? 32'hFFFF_FFFF :
                       (sc_mem.exists(c_addr[31:2]) ? sc_mem[c_addr[31:2]] : dflt(c_addr[31:2]));
          pend = 1'b0;
        end
        wcnt++;
      end
      if (sc_memory_access_o) begin
        if (prev_acc) chk("pulse_width", prev_acc, 1'b0);
        pulses++;
        c_addr  = sc_addr_o;
        c_we    = sc_is_writing_o;
        c_be    = sc_be_o;
        c_wdata = sc_d_in_o;
        to_mode = (c_addr[31:16] == 16'h0001);
        lat     = (!to_mode && lat_q.size() != 0) ? lat_q.pop_front() : 0;
        if (c_we && !to_mode) begin
          sc_mem[c_addr[31:2]] = merge(sc_mem.exists(c_addr[31:2]) ? sc_mem[c_addr[31:2]] :
                                       dflt(c_addr[31:2]), c_be, c_wdata);
        end
        pend = 1'b1;
        wcnt = 0;
      end
      prev_acc = sc_memory_access_o;
    end
  end

  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge clk);
      if (rst && mem_rvalid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid actual=1 required=0");
        end else begin
          e = exp_q.pop_front();
          chk("rdata", mem_rdata_o, e.rdata);
          chk("err", mem_err_o, e.err);
        end
      end
    end
  end

  initial begin : guard
    #800000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin : stim
    int c;
    logic [31:0] a;
    logic        w;
    rst = 1'b0;
    mem_req_i = 1'b0; mem_addr_i = '0; mem_we_i = 1'b0; mem_be_i = '0; mem_wdata_i = '0;
    #1;
    chk("reset_outputs", {mem_gnt_o, mem_rvalid_o, mem_rdata_o, mem_err_o, sc_memory_access_o,
        sc_is_writing_o, sc_addr_o, sc_d_in_o, sc_be_o, busy_o}, '0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("gnt_after_reset", mem_gnt_o, 1'b1);
    @(negedge clk);

    // Single SRAM read, controller answers in the first WAIT cycle.
    ref_mem[30'h4] = 32'hDEAD_BEEF;
    sc_mem[30'h4]  = 32'hDEAD_BEEF;
    send(32'h0000_0010, 1'b0, 4'hF, '0, 0);
    c = last_gnt_cyc;
    wait_rvalid();
    chk("read_latency", cyc - c, 4);
    drain();

    // Back-to-back requests against a stalling controller fill the FIFO.
    send(32'h0000_0040, 1'b0, 4'hF, '0, 12);
    send(32'h0000_0044, 1'b0, 4'hF, '0, 12);
    send(32'h0000_0048, 1'b0, 4'hF, '0, 12);
    send(32'h0000_004C, 1'b0, 4'hF, '0, 12);
    chk("gnt_backpressure", last_waited, 1'b1);
    drain();

    // Out-of-range write is rejected without touching the controller.
    c = pulses;
    send(32'h0000_2000, 1'b1, 4'hF, 32'hCAFE_F00D, 0);
    drain();
    chk("reject_no_pulse", pulses, c);

    // Timeout, then a late completion that must be dropped.
    send(32'h0001_0000, 1'b0, 4'hF, '0, 0);
    send(32'h0000_0020, 1'b0, 4'hF, '0, 2);
    wait_access();
    c = cyc;
    @(negedge clk);
    wait_rvalid();
    chk("timeout_latency", cyc - c, TO_CYC + 1);
    drain();

    // Write with partial byte enables, then read it back.
    send(32'h0000_0100, 1'b1, 4'b0011, 32'h1234_5678, 5);
    wait_access();
    chk("write_qualifiers", {sc_is_writing_o, sc_be_o, sc_d_in_o}, {1'b1, 4'b0011, 32'h1234_5678});
    drain();
    send(32'h0000_0100, 1'b0, 4'hF, '0, 1);
    drain();

    // Completion exactly on the last counted WAIT cycle still succeeds.
    send(32'h0000_0030, 1'b0, 4'hF, '0, TO_CYC - 1);
    drain();

    // Reset during WAIT abandons the transaction and the queued request.
    send(32'h0001_0040, 1'b0, 4'hF, '0, 0);
    send(32'h0000_0024, 1'b0, 4'hF, '0, 3);
    wait_access();
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", {mem_gnt_o, mem_rvalid_o, mem_rdata_o, mem_err_o,
        sc_memory_access_o, sc_is_writing_o, sc_addr_o, sc_d_in_o, sc_be_o, busy_o}, '0);
    exp_q.delete();
    lat_q.delete();
    exp_pulses--;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("release_state", {busy_o, mem_gnt_o}, 2'b01);
    repeat (12) @(negedge clk);
    chk("post_reset_idle", {busy_o, mem_rvalid_o}, 2'b00);

    // Randomised mix of regions, boundaries, latencies and gaps.
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        6: begin
          c = $urandom_range(0, 3);
          a = (c == 0) ? 32'h0000_0FFC : (c == 1) ? 32'h0000_0FFE :
              (c == 2) ? 32'h0000_0FFF : 32'h0000_1000;
        end
        7: a = 32'h0000_2000 + {$urandom_range(0, 15), 2'b00};
        8: begin
          a = 32'h0001_0000 + {$urandom_range(0, 15), 2'b00};
          w = 1'b0;
        end
        default: a = {$urandom_range(0, 31), 2'b00};
      endcase
      send(a, w, 4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 7) == 0) ? 15 :
           $urandom_range(0, 10));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    chk("pulse_count", pulses, exp_pulses);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
